// File: rtl/rs232c_pkg.sv
// Shared types and constants for the RS-232C transmit stream: FSM states,
// parity encodings, line levels and the parity helper.
package rs232c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } parity_mode_e;

    localparam logic DEFAULT_BIT = 1'b1;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;

    localparam int MAX_DATA_WIDTH = 9;

    // Callers zero-extend narrower words; padding zeros leave the XOR unchanged.
    function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                        input parity_mode_e              mode);
        case (mode)
            PAR_EVEN: return ^data;
            PAR_ODD:  return ~(^data);
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rs232c_tx_stream_sync_fifo.sv
// Single-clock FIFO with fall-through read data and a registered occupancy level.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  do_push, do_pop;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/rs232c_tx_stream.sv
// Buffered RS-232C transmitter: words queue in a FIFO and are sent as
// start / data (LSB first) / optional parity / 1-2 stop frames.
module rs232c_tx_stream
    import rs232c_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          txd,
    output logic                          t_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  baud_q, baud_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    parity_mode_e          mode_q, mode_d;
    logic                  two_stop_q, two_stop_d;
    logic                  txd_q, txd_d;
    logic                  t_busy_q, t_busy_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  bit_done, start_frame;

    // Counter reload for one bit time of max(div, 2) cycles.
    function automatic logic [DIV_WIDTH-1:0] bit_reload(input logic [DIV_WIDTH-1:0] div);
        return (div < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : div - DIV_WIDTH'(1);
    endfunction

    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;
    assign txd       = txd_q;
    assign t_busy    = t_busy_q;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (s_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            word_q     <= '0;
            mode_q     <= PAR_NONE;
            two_stop_q <= 1'b0;
            txd_q      <= DEFAULT_BIT;
            t_busy_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            word_q     <= word_d;
            mode_q     <= mode_d;
            two_stop_q <= two_stop_d;
            txd_q      <= txd_d;
            t_busy_q   <= t_busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        word_d      = word_q;
        mode_d      = mode_q;
        two_stop_d  = two_stop_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;
        bit_done    = (cnt_q == '0);

        if (state_q != IDLE) begin
            cnt_d = bit_done ? bit_reload(baud_q) : cnt_q - DIV_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                start_frame = !fifo_empty;
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d    = (mode_q != PAR_NONE) ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (two_stop_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame settings are captured only here, so mid-frame input changes wait for the next word.
        if (start_frame) begin
            fifo_pop   = 1'b1;
            state_d    = START;
            word_d     = fifo_rd_data;
            mode_d     = parity_mode_e'(parity_mode);
            two_stop_d = two_stop;
            baud_d     = baud_div;
            cnt_d      = bit_reload(baud_div);
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
        end
    end

    // Outputs are registered from the current state, so txd trails the state by one cycle.
    always_comb begin
        t_busy_d = (state_q != IDLE);
        txd_d    = DEFAULT_BIT;
        case (state_q)
            START:   txd_d = START_BIT;
            DATA:    txd_d = word_q[bit_idx_q];
            PARITY:  txd_d = parity_bit(MAX_DATA_WIDTH'(word_q), mode_q);
            STOP:    txd_d = STOP_BIT;
            default: txd_d = DEFAULT_BIT;
        endcase
    end

endmodule

// File: tb/tb_rs232c_tx_stream.sv
// Scoreboard bench: stimulus queues hand-computed frames, a monitor decodes
// txd/t_busy cycle by cycle against the queue head.
module tb_rs232c_tx_stream;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] baud_div;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        txd;
    logic        t_busy;
    logic [2:0]  fifo_level;

    typedef struct {
        logic [7:0] data;
        bit         has_par;
        bit         par;
        bit         two;
        int         bt;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    rs232c_tx_stream #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4),
        .DIV_WIDTH  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .txd         (txd),
        .t_busy      (t_busy),
        .fifo_level  (fifo_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input bit hp, input bit p,
                                input bit two, input int bt, input bit b2b);
        exp_t e;
        e.data = d; e.has_par = hp; e.par = p; e.two = two; e.bt = bt; e.b2b = b2b;
        return e;
    endfunction

    // Called at a negedge; leaves s_valid high and returns at the negedge after acceptance.
    task automatic push_word(input logic [7:0] d, input exp_t e);
        int g = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            n_total++; n_bad++;
            $display("FAIL push_timeout: s_ready stuck low for word 0x%0h", d);
        end
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int g = 0;
        repeat (3) @(negedge clk);
        while ((t_busy !== 1'b0 || fifo_level !== 3'd0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            n_total++; n_bad++;
            $display("FAIL idle_timeout: t_busy=%b level=%0d", t_busy, fifo_level);
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: detects a start bit, pops the expected frame and checks every cycle.
    initial begin : monitor
        exp_t       f;
        logic       bits [12];
        int         nbits, ncyc, wave_err, bi;
        logic [7:0] got;
        bit         pending, aborted;
        pending = 1'b0;
        forever begin
            if (!pending) @(negedge clk);
            pending = 1'b0;
            if (rst !== 1'b0 || txd !== 1'b0) continue;
            if (exp_q.size() == 0) begin
                n_total++; n_bad++;
                $display("FAIL unexpected_frame: txd low at %0t with nothing queued", $time);
                for (int g = 0; g < 3000 && t_busy === 1'b1; g++) @(negedge clk);
                continue;
            end
            f = exp_q.pop_front();
            bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) bits[1 + i] = f.data[i];
            nbits = 9;
            if (f.has_par) begin bits[nbits] = f.par; nbits++; end
            bits[nbits] = 1'b1; nbits++;
            if (f.two) begin bits[nbits] = 1'b1; nbits++; end
            ncyc     = nbits * f.bt;
            wave_err = 0;
            got      = '0;
            aborted  = 1'b0;
            for (int c = 0; c < ncyc; c++) begin
                if (c > 0) @(negedge clk);
                if (rst !== 1'b0) begin aborted = 1'b1; break; end
                bi = c / f.bt;
                if (txd !== bits[bi] || t_busy !== 1'b1) wave_err++;
                if (bi >= 1 && bi <= 8 && (c % f.bt) == f.bt / 2) got[bi - 1] = txd;
            end
            if (aborted) continue;
            check("frame_wave_errors", wave_err, 0);
            check("frame_data", {24'd0, got}, {24'd0, f.data});
            @(negedge clk);
            if (rst !== 1'b0) continue;
            if (exp_q.size() > 0 && exp_q[0].b2b) begin
                check("b2b_start_txd", {31'd0, txd}, 32'd0);
            end else begin
                check("idle_txd", {31'd0, txd}, 32'd1);
                check("idle_busy", {31'd0, t_busy}, 32'd0);
            end
            pending = 1'b1;
        end
    end

    initial begin : stimulus
        int quiet;
        int g;
        rst         = 1'b1;
        s_valid     = 1'b0;
        s_data      = 8'hEE;
        baud_div    = 32'd4;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd",     {31'd0, txd},     32'd1);
        check("rst_busy",    {31'd0, t_busy},  32'd0);
        check("rst_level",   {29'd0, fifo_level}, 32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);
        // A word offered while in reset must not be taken.
        s_valid = 1'b1;
        repeat (2) @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        check("rst_no_accept", {29'd0, fifo_level}, 32'd0);

        // 0x55, no parity, one stop, 4 cycles per bit.
        push_word(8'h55, mk(8'h55, 0, 0, 0, 4, 0)); s_valid = 1'b0; wait_idle();

        // Parity variants on 0x07 (three ones) and 0x00 odd.
        parity_mode = 2'b01; push_word(8'h07, mk(8'h07, 1, 1, 0, 4, 0)); s_valid = 1'b0; wait_idle();
        parity_mode = 2'b10; push_word(8'h07, mk(8'h07, 1, 0, 0, 4, 0)); s_valid = 1'b0; wait_idle();
        parity_mode = 2'b11; push_word(8'h07, mk(8'h07, 1, 1, 0, 4, 0)); s_valid = 1'b0; wait_idle();
        parity_mode = 2'b10; push_word(8'h00, mk(8'h00, 1, 1, 0, 4, 0)); s_valid = 1'b0; wait_idle();
        parity_mode = 2'b00; two_stop = 1'b1;
        push_word(8'h07, mk(8'h07, 0, 0, 1, 4, 0)); s_valid = 1'b0; wait_idle();
        two_stop = 1'b0;

        // Divisors below two clamp to a two-cycle bit.
        baud_div = 32'd0; push_word(8'hA5, mk(8'hA5, 0, 0, 0, 2, 0)); s_valid = 1'b0; wait_idle();
        baud_div = 32'd1; push_word(8'h3C, mk(8'h3C, 0, 0, 0, 2, 0)); s_valid = 1'b0; wait_idle();

        // Settings changed mid-frame apply only to the following frame.
        baud_div = 32'd4;
        push_word(8'h12, mk(8'h12, 0, 0, 0, 4, 0));
        push_word(8'h34, mk(8'h34, 1, 1, 0, 8, 1));
        s_valid = 1'b0;
        g = 0;
        while (t_busy !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        check("busy_before_change", {31'd0, t_busy}, 32'd1);
        baud_div    = 32'd8;
        parity_mode = 2'b01;
        wait_idle();

        // Six words with s_valid held: fills the 4-deep buffer, frames run back to back.
        baud_div = 32'd2; parity_mode = 2'b00;
        push_word(8'h01, mk(8'h01, 0, 0, 0, 2, 0));
        push_word(8'h23, mk(8'h23, 0, 0, 0, 2, 1));
        push_word(8'h45, mk(8'h45, 0, 0, 0, 2, 1));
        push_word(8'h67, mk(8'h67, 0, 0, 0, 2, 1));
        push_word(8'h89, mk(8'h89, 0, 0, 0, 2, 1));
        check("full_level",   {29'd0, fifo_level}, 32'd4);
        check("full_s_ready", {31'd0, s_ready},    32'd0);
        push_word(8'hAB, mk(8'hAB, 0, 0, 0, 2, 1));
        s_valid = 1'b0;
        wait_idle();

        // Reset during data bit 3 with two words still buffered.
        baud_div = 32'd4;
        push_word(8'hF0, mk(8'hF0, 0, 0, 0, 4, 0));
        push_word(8'h0F, mk(8'h0F, 0, 0, 0, 4, 1));
        push_word(8'h33, mk(8'h33, 0, 0, 0, 4, 1));
        s_valid = 1'b0;
        g = 0;
        while (txd !== 1'b0 && g < 100) begin @(negedge clk); g++; end
        check("start_seen", {31'd0, txd}, 32'd0);
        repeat (17) @(negedge clk);
        check("pre_rst_level", {29'd0, fifo_level}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("abort_txd",     {31'd0, txd},     32'd1);
        check("abort_busy",    {31'd0, t_busy},  32'd0);
        check("abort_level",   {29'd0, fifo_level}, 32'd0);
        check("abort_s_ready", {31'd0, s_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        quiet = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (t_busy !== 1'b0 || txd !== 1'b1) quiet++;
        end
        check("post_rst_quiet", quiet, 0);
        push_word(8'h5A, mk(8'h5A, 0, 0, 0, 4, 0)); s_valid = 1'b0; wait_idle();

        check("frames_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
